// File: rtl/jesd204_tx_multilink_ctrl.sv
// rtl/jesd204_tx_multilink_ctrl.sv - JESD204 TX link-layer controller with per-link CGS/ILAS/DATA state machines
module jesd204_tx_multilink_ctrl #(
  parameter int NUM_LANES    = 4,
  parameter int NUM_LINKS    = 2,
  parameter int SYNC_LOW_MIN = 4,
  parameter int ALIGN_LINKS  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lmfc_edge,
  input  logic [NUM_LINKS-1:0]   sync,
  input  logic [NUM_LINKS-1:0]   cfg_links_disable,
  input  logic [NUM_LANES-1:0]   cfg_lanes_disable,
  input  logic [7:0]             cfg_mframes_per_ilas,
  input  logic                   cfg_skip_ilas,
  input  logic                   cfg_continuous_cgs,
  input  logic                   ctrl_manual_sync_request,
  output logic [NUM_LANES-1:0]   lane_cgs_enable,
  output logic [NUM_LANES-1:0]   lane_ilas_enable,
  output logic [8*NUM_LINKS-1:0] link_ilas_mf_index,
  output logic [NUM_LINKS-1:0]   link_tx_ready,
  output logic                   tx_ready,
  output logic [NUM_LINKS-1:0]   status_sync,
  output logic [2*NUM_LINKS-1:0] status_state
);

  localparam int         LANES_PER_LINK = NUM_LANES / NUM_LINKS;
  localparam logic [8:0] LOW_MIN        = 9'(SYNC_LOW_MIN);

  typedef enum logic [1:0] {
    ST_CGS  = 2'b00,
    ST_ILAS = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t         state_q     [NUM_LINKS];
  state_t         state_d     [NUM_LINKS];
  logic [7:0]     ilas_cnt_q  [NUM_LINKS];
  logic [7:0]     ilas_cnt_d  [NUM_LINKS];
  logic [7:0]     ilas_last_q [NUM_LINKS];
  logic [7:0]     ilas_last_d [NUM_LINKS];
  logic [7:0]     low_cnt_q   [NUM_LINKS];
  logic [7:0]     low_cnt_d   [NUM_LINKS];
  logic [8:0]     low_inc     [NUM_LINKS];

  logic [NUM_LINKS-1:0] go;
  logic [NUM_LINKS-1:0] resync;
  logic [NUM_LINKS-1:0] leave_cgs;
  logic                 any_enabled;
  logic                 all_go;

  logic [NUM_LANES-1:0] cgs_en_d;
  logic [NUM_LANES-1:0] ilas_en_d;
  logic [NUM_LINKS-1:0] ready_d;
  logic                 tx_ready_d;

  // Which links are allowed to start, and whether every enabled link agrees
  always_comb begin
    go          = sync & ~cfg_links_disable &
                  {NUM_LINKS{~cfg_continuous_cgs & ~ctrl_manual_sync_request}};
    any_enabled = ~&cfg_links_disable;
    all_go      = &(go | cfg_links_disable);
  end

  // Per-link next state; a resync request always outranks a coincident LMFC edge
  always_comb begin
    for (int k = 0; k < NUM_LINKS; k++) begin
      low_inc[k]     = {1'b0, low_cnt_q[k]} + 9'd1;
      resync[k]      = ctrl_manual_sync_request | cfg_links_disable[k] |
                       (~sync[k] & (low_inc[k] >= LOW_MIN));
      if (ALIGN_LINKS != 0)
        leave_cgs[k] = lmfc_edge & any_enabled & all_go & ~cfg_links_disable[k];
      else
        leave_cgs[k] = lmfc_edge & go[k];

      state_d[k]     = state_q[k];
      ilas_cnt_d[k]  = ilas_cnt_q[k];
      ilas_last_d[k] = ilas_last_q[k];
      low_cnt_d[k]   = sync[k] ? 8'd0 : (low_inc[k][8] ? 8'hff : low_inc[k][7:0]);

      case (state_q[k])
        ST_CGS: begin
          low_cnt_d[k] = 8'd0;
          if (leave_cgs[k]) begin
            state_d[k]     = cfg_skip_ilas ? ST_DATA : ST_ILAS;
            ilas_cnt_d[k]  = 8'd0;
            ilas_last_d[k] = cfg_mframes_per_ilas;
          end
        end
        ST_ILAS: begin
          if (resync[k]) begin
            state_d[k]    = ST_CGS;
            ilas_cnt_d[k] = 8'd0;
            low_cnt_d[k]  = 8'd0;
          end else if (lmfc_edge) begin
            if (ilas_cnt_q[k] == ilas_last_q[k])
              state_d[k] = ST_DATA;
            else
              ilas_cnt_d[k] = ilas_cnt_q[k] + 8'd1;
          end
        end
        default: begin
          if (resync[k]) begin
            state_d[k]    = ST_CGS;
            ilas_cnt_d[k] = 8'd0;
            low_cnt_d[k]  = 8'd0;
          end
        end
      endcase
    end
  end

  // Lane and link output decode from the next state, so outputs line up with state
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      cgs_en_d[i]  = (state_d[i / LANES_PER_LINK] == ST_CGS) &
                     ~cfg_links_disable[i / LANES_PER_LINK] & ~cfg_lanes_disable[i];
      ilas_en_d[i] = (state_d[i / LANES_PER_LINK] == ST_ILAS) &
                     ~cfg_links_disable[i / LANES_PER_LINK] & ~cfg_lanes_disable[i];
    end
    for (int k = 0; k < NUM_LINKS; k++)
      ready_d[k] = (state_d[k] == ST_DATA);
    tx_ready_d = any_enabled & &(ready_d | cfg_links_disable);
  end

  // State and registered outputs; reset clears everything including the outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_LINKS; k++) begin
        state_q[k]     <= ST_CGS;
        ilas_cnt_q[k]  <= 8'd0;
        ilas_last_q[k] <= 8'd0;
        low_cnt_q[k]   <= 8'd0;
      end
      lane_cgs_enable    <= '0;
      lane_ilas_enable   <= '0;
      link_ilas_mf_index <= '0;
      link_tx_ready      <= '0;
      tx_ready           <= 1'b0;
      status_sync        <= '0;
      status_state       <= '0;
    end else begin
      for (int k = 0; k < NUM_LINKS; k++) begin
        state_q[k]                   <= state_d[k];
        ilas_cnt_q[k]                <= ilas_cnt_d[k];
        ilas_last_q[k]               <= ilas_last_d[k];
        low_cnt_q[k]                 <= low_cnt_d[k];
        link_ilas_mf_index[8*k +: 8] <= ilas_cnt_d[k];
        status_state[2*k +: 2]       <= state_d[k];
      end
      lane_cgs_enable  <= cgs_en_d;
      lane_ilas_enable <= ilas_en_d;
      link_tx_ready    <= ready_d;
      tx_ready         <= tx_ready_d;
      status_sync      <= sync;
    end
  end

endmodule
